// File: rtl/daq_pkg.sv
// Shared DAQ constants and the occupancy-update encoding used by FIFO logic.
package daq_pkg;

  // Default word width and address width for DAQ storage blocks.
  localparam int DAQ_DATA_WIDTH = 8;
  localparam int DAQ_ADDR_WIDTH = 10;

  // What happens to occupancy on an enabled clock edge.
  typedef enum logic [1:0] {
    OCC_HOLD = 2'b00,
    OCC_PUSH = 2'b01,
    OCC_POP  = 2'b10,
    OCC_BOTH = 2'b11
  } occ_op_t;

endpackage

// File: rtl/daq_fifo_dpram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Read-first behaviour: a read and write to the same address in one cycle
// returns the old word, which the FIFO relies on when read and write meet at Full.
module daq_fifo_dpram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Storage array and read register; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/daq_fifo.sv
// Synchronous FIFO for DAQ sample buffering: pointers, occupancy, registered
// flags and sticky overflow around a block-RAM style storage sub-module.
module daq_fifo
  import daq_pkg::*;
#(
  parameter int DATA_WIDTH = DAQ_DATA_WIDTH,
  parameter int ADDR_WIDTH = DAQ_ADDR_WIDTH,
  parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ClockEn,
  input  logic                  Clear,
  input  logic                  WrEn,
  input  logic [DATA_WIDTH-1:0] WrData,
  input  logic                  RdEn,
  output logic [DATA_WIDTH-1:0] RdData,
  output logic                  RdValid,
  output logic                  Empty,
  output logic                  Full,
  output logic                  AlmostFull,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Overflow
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  empty_r;
  logic                  full_r;
  logic                  af_r;
  logic                  valid_r;
  logic                  ovf_r;
  logic                  rd_seen_r;

  logic                  rd_acc_s;
  logic                  wr_acc_s;
  logic                  ram_we_s;
  logic                  ram_re_s;
  occ_op_t               occ_op_s;
  logic [ADDR_WIDTH:0]   count_next_s;
  logic [DATA_WIDTH-1:0] ram_q_s;

  // Acceptance decisions and next occupancy; flags only come from registers.
  always_comb begin
    rd_acc_s     = RdEn & ~empty_r;
    wr_acc_s     = WrEn & (~full_r | rd_acc_s);
    occ_op_s     = occ_op_t'({rd_acc_s, wr_acc_s});
    count_next_s = count_r;
    case (occ_op_s)
      OCC_PUSH: count_next_s = count_r + CNT_ONE;
      OCC_POP:  count_next_s = count_r - CNT_ONE;
      OCC_BOTH: count_next_s = count_r;
      default:  count_next_s = count_r;
    endcase
    ram_we_s = ClockEn & ~Clear & wr_acc_s;
    ram_re_s = ClockEn & ~Clear & rd_acc_s;
  end

  // Pointer, occupancy, flag and status registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      empty_r   <= 1'b1;
      full_r    <= 1'b0;
      af_r      <= 1'b0;
      valid_r   <= 1'b0;
      ovf_r     <= 1'b0;
      rd_seen_r <= 1'b0;
    end else if (ClockEn) begin
      if (Clear) begin
        // Flush: RdData holds because the RAM read register is not enabled.
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        count_r  <= '0;
        empty_r  <= 1'b1;
        full_r   <= 1'b0;
        af_r     <= 1'b0;
        valid_r  <= 1'b0;
        ovf_r    <= 1'b0;
      end else begin
        if (wr_acc_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (rd_acc_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
        count_r   <= count_next_s;
        empty_r   <= (count_next_s == '0);
        full_r    <= (count_next_s == DEPTH_CNT);
        af_r      <= (count_next_s >= AF_CNT);
        valid_r   <= rd_acc_s;
        ovf_r     <= ovf_r | (WrEn & ~wr_acc_s);
        rd_seen_r <= rd_seen_r | rd_acc_s;
      end
    end
  end

  daq_fifo_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (Clock),
    .we    (ram_we_s),
    .waddr (wr_ptr_r),
    .wdata (WrData),
    .re    (ram_re_s),
    .raddr (rd_ptr_r),
    .rdata (ram_q_s)
  );

  // The RAM read register has no reset, so RdData reads as zero until the
  // first accepted read after reset has loaded it.
  assign RdData     = rd_seen_r ? ram_q_s : '0;
  assign RdValid    = valid_r;
  assign Empty      = empty_r;
  assign Full       = full_r;
  assign AlmostFull = af_r;
  assign Count      = count_r;
  assign Overflow   = ovf_r;

endmodule

// File: tb/tb_daq_fifo.sv
// Self-checking bench for daq_fifo (8-bit words, 16 deep, AlmostFull at 12).
module tb_daq_fifo;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AFL = 12;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          ClockEn = 1'b0;
  logic          Clear = 1'b0;
  logic          WrEn = 1'b0;
  logic [DW-1:0] WrData = '0;
  logic          RdEn = 1'b0;
  logic [DW-1:0] RdData;
  logic          RdValid;
  logic          Empty;
  logic          Full;
  logic          AlmostFull;
  logic [AW:0]   Count;
  logic          Overflow;

  int total = 0;
  int bad = 0;

  // Reference model: a plain queue of stored words plus status.
  logic [DW-1:0] mq[$];
  logic          m_ovf = 1'b0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_rd = '0;

  typedef struct {
    logic          ce;
    logic          clr;
    logic          we;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW:0]   cnt;
    logic          vld;
    logic [DW-1:0] dat;
  } vec_t;

  vec_t tbl[14];

  daq_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_LEVEL   (AFL)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ClockEn    (ClockEn),
    .Clear      (Clear),
    .WrEn       (WrEn),
    .WrData     (WrData),
    .RdEn       (RdEn),
    .RdData     (RdData),
    .RdValid    (RdValid),
    .Empty      (Empty),
    .Full       (Full),
    .AlmostFull (AlmostFull),
    .Count      (Count),
    .Overflow   (Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_valid = 1'b0;
    m_rd = '0;
  endtask

  task automatic model_step(input logic ce, input logic clr, input logic we,
                            input logic [DW-1:0] wd, input logic re);
    bit can_rd;
    bit can_wr;
    if (ce) begin
      if (clr) begin
        mq.delete();
        m_ovf = 1'b0;
        m_valid = 1'b0;
      end else begin
        can_rd = re && (mq.size() > 0);
        can_wr = we && ((mq.size() < DEPTH) || can_rd);
        if (can_rd) begin
          m_rd = mq.pop_front();
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
        if (can_wr) mq.push_back(wd);
        if (we && !can_wr) m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".count"}, 32'(Count), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(Empty), 32'(mq.size() == 0));
    chk({tag, ".full"}, 32'(Full), 32'(mq.size() == DEPTH));
    chk({tag, ".afull"}, 32'(AlmostFull), 32'(mq.size() >= AFL));
    chk({tag, ".valid"}, 32'(RdValid), 32'(m_valid));
    chk({tag, ".rddata"}, 32'(RdData), 32'(m_rd));
    chk({tag, ".ovf"}, 32'(Overflow), 32'(m_ovf));
  endtask

  task automatic cycle(input string tag, input logic ce, input logic clr, input logic we,
                       input logic [DW-1:0] wd, input logic re);
    ClockEn = ce;
    Clear = clr;
    WrEn = we;
    WrData = wd;
    RdEn = re;
    @(posedge Clock);
    #1;
    model_step(ce, clr, we, wd, re);
    compare_all(tag);
  endtask

  initial begin
    logic [DW-1:0] last_rd;
    bit            seen_aa;
    int            cnt_before;

    // Directed vectors: five writes, five reads, then read-while-empty.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 5'd1, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 5'd2, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 5'd3, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h04, 1'b0, 5'd4, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 5'd5, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd4, 1'b1, 8'h01};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd3, 1'b1, 8'h02};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 8'h03};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'h04};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'h05};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h05};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 5'd1, 1'b0, 8'h05};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'h33};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h33};

    // Reset state.
    repeat (2) @(posedge Clock);
    #1;
    model_reset();
    compare_all("reset");
    Reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cycle("tbl", tbl[i].ce, tbl[i].clr, tbl[i].we, tbl[i].wd, tbl[i].re);
      chk($sformatf("tbl%0d.count", i), 32'(Count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.valid", i), 32'(RdValid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d.data", i), 32'(RdData), 32'(tbl[i].dat));
    end

    // Fill to Full, then an overflowing write of 0xAA.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
    chk("full.flag", 32'(Full), 32'd1);
    chk("full.count", 32'(Count), 32'd16);
    cycle("ovf", 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
    chk("ovf.flag", 32'(Overflow), 32'd1);
    chk("ovf.count", 32'(Count), 32'd16);

    // Simultaneous read and write at Full: both accepted, 0x55 comes out last.
    cycle("rdwr_full", 1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
    chk("rdwr_full.count", 32'(Count), 32'd16);
    chk("rdwr_full.data", 32'(RdData), 32'h10);
    seen_aa = 1'b0;
    last_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cycle("drain", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      if (RdData == 8'hAA) seen_aa = 1'b1;
      last_rd = RdData;
    end
    chk("drain.no_aa", 32'(seen_aa), 32'd0);
    chk("drain.last55", 32'(last_rd), 32'h55);
    chk("drain.ovf_sticky", 32'(Overflow), 32'd1);
    cycle("clear", 1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
    chk("clear.ovf", 32'(Overflow), 32'd0);
    chk("clear.rdheld", 32'(RdData), 32'h55);

    // Randomised interleaved traffic with pointer wrap, occasional stall/clear.
    for (int i = 0; i < 400; i++) begin
      logic ce;
      logic clr;
      logic we;
      logic re;
      ce  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 99) == 0);
      if (i < 200) begin
        we = ($urandom_range(0, 99) < 60);
        re = ($urandom_range(0, 99) < 40);
      end else begin
        we = ($urandom_range(0, 99) < 40);
        re = ($urandom_range(0, 99) < 60);
      end
      cycle("rand", ce, clr, we, 8'($urandom), re);
    end

    // Reset mid-stream with seven words buffered.
    cycle("pre_rst_clr", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) cycle("pre_rst", 1'b1, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    cycle("pre_rst_rd", 1'b1, 1'b0, 1'b1, 8'hC7, 1'b1);
    chk("pre_rst.count", 32'(Count), 32'd7);
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    chk("async_rst.count", 32'(Count), 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b1;

    // Stalled clock enable holds all state.
    cycle("post_rst_w1", 1'b1, 1'b0, 1'b1, 8'hD1, 1'b0);
    cycle("post_rst_w2", 1'b1, 1'b0, 1'b1, 8'hD2, 1'b0);
    cnt_before = 32'(Count);
    for (int i = 0; i < 3; i++) cycle("stall", 1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
    chk("stall.count", 32'(Count), 32'(cnt_before));
    cycle("post_rst_r1", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_rst.first", 32'(RdData), 32'hD1);
    cycle("post_rst_r2", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    cycle("post_rst_idle", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/daq_fifo.md
DAQ_FIFO -- requirements
Module: daq_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the width in bits of each stored word.
REQ-002 Parameter ADDR_WIDTH, default 10, sets the depth: DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter AF_LEVEL, default DEPTH-16, is the occupancy at or above which AlmostFull asserts.
REQ-004 Clock  in  1  sole clock; all logic is rising-edge triggered.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 ClockEn  in  1  global enable; when low, all state holds.
REQ-007 Clear  in  1  synchronous flush.
REQ-008 WrEn  in  1  write request.
REQ-009 WrData  in  DATA_WIDTH  write word.
REQ-010 RdEn  in  1  read request.
REQ-011 RdData  out  DATA_WIDTH  registered read word.
REQ-012 RdValid  out  1  RdData carries a newly read word this cycle.
REQ-013 Empty  out  1  occupancy is 0.
REQ-014 Full  out  1  occupancy is DEPTH.
REQ-015 AlmostFull  out  1  occupancy >= AF_LEVEL.
REQ-016 Count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-017 Overflow  out  1  sticky flag: a write was dropped.

Function
REQ-018 All state updates shall occur only on rising Clock edges with ClockEn=1; with ClockEn=0 every output and internal register shall hold.
REQ-019 Write acceptance: WrEn=1 and (Full=0 or read accepted in the same cycle) -> WrData stored at the write pointer, write pointer +1 modulo DEPTH.
REQ-020 Read acceptance: RdEn=1 and Empty=0 -> word at the read pointer is registered to RdData, read pointer +1 modulo DEPTH.
REQ-021 Read latency shall be one cycle: RdValid=1 on the edge after acceptance for exactly one cycle; RdData shall hold its last value otherwise.
REQ-022 A read with Empty=1 shall be ignored; no RdValid pulse, no pointer change, not an error; a same-cycle write is still accepted.
REQ-023 A write with Full=1 and no same-cycle accepted read shall be dropped, with no pointer or Count change, and shall set Overflow.
REQ-024 A simultaneous accepted read and write shall leave Count unchanged; at Full, both are accepted.
REQ-025 Count shall be +1 on write only, -1 on read only, and unchanged otherwise; Empty, Full and AlmostFull shall be registered and consistent with Count in the same cycle.
REQ-026 Pointers shall be ADDR_WIDTH wide and wrap DEPTH-1 -> 0 with no discontinuity in data order.
REQ-027 Clear=1 (with ClockEn=1) shall take priority over WrEn and RdEn: both pointers 0, Count 0, Empty 1, Full 0, AlmostFull 0, RdValid 0, Overflow 0, RdData held, and memory contents not erased.
REQ-028 Overflow shall stay set until Clear or Reset.
REQ-029 Data shall be read out in exact write order; no word is duplicated or lost except dropped overflow writes.

Reset
REQ-030 Reset low shall immediately force pointers 0, Count 0, Empty 1, Full 0, AlmostFull 0, RdValid 0, Overflow 0, and RdData 0, regardless of ClockEn.
REQ-031 Reset low mid-operation shall discard all buffered words; memory contents are undefined after reset and shall not be relied upon.
REQ-032 On release of Reset, the first accepted write shall land at address 0.

Structure
REQ-033 Shared package daq_pkg shall hold the default DATA_WIDTH and ADDR_WIDTH constants used across DAQ blocks.
REQ-034 Storage shall be a sub-module daq_fifo_dpram: a simple dual-port synchronous RAM (one write port, one registered read port), parametrised by DATA_WIDTH and ADDR_WIDTH, with no reset on its array and mappable to block RAM.
REQ-035 Pointer, count and flag logic shall live in daq_fifo; no combinational path shall run from WrEn or RdEn to any output.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4 unless noted)
REQ-036 Write 0x01..0x05, then read 5 -> RdData 0x01..0x05, each with a one-cycle RdValid one cycle after RdEn; Empty=1 and Count=0 at the end.
REQ-037 Write 16 words -> Full=1 and Count=16; a 17th write (0xAA) -> dropped, Overflow=1; read 16 -> no 0xAA appears; Overflow stays 1 until Clear.
REQ-038 At Full, RdEn=1 and WrEn=1 with 0x55 -> Count stays 16; 0x55 is read out last.
REQ-039 RdEn=1 while Empty -> no RdValid; same-cycle WrEn with 0x33 -> Count=1; next read returns 0x33.
REQ-040 Perform 40 writes and reads interleaved (pointer wrap) -> output sequence equals input sequence; AlmostFull=1 whenever Count>=AF_LEVEL.
REQ-041 Reset low mid-stream with Count=7 -> outputs take reset values asynchronously; ClockEn=0 for 3 cycles with WrEn=1 -> Count unchanged.
